multi_btn_debouncer: RTL and testbench

Parametrised multi-channel push-button debouncer for the board-level input path. It sits between the raw button pins and user logic. Each of `N_BTN` asynchronous inputs is synchronised, sampled on a shared sample tick, and accepted only after `N_STABLE` consecutive disagreeing samples. The block outputs a clean level per channel plus single-cycle press (`btn_rise`) and release (`btn_fall`) pulses. Everything runs in the `clk` domain: no derived clock, unlike the previous debouncer.

---
 rtl/multi_btn_debouncer.sv | 95 +++++++++
 tb/tb_multi_btn_debouncer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multi_btn_debouncer.sv
// Multi-channel push-button debouncer: synchroniser, shared sample tick,
// N_STABLE-sample acceptance, clean level plus rise/fall pulses per channel.
module multi_btn_debouncer #(
  parameter int N_BTN       = 4,
  parameter int CLOCK_FREQ  = 100,
  parameter int T_SAMPLE_US = 100,
  parameter int N_STABLE    = 20,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic             sample_tick
);

  localparam int TICK_DIV = CLOCK_FREQ * T_SAMPLE_US;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(N_STABLE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STABLE - 1);

  logic [N_BTN-1:0] x;
  logic [N_BTN-1:0] s1_q, s2_q;

  logic [DIV_W-1:0] div_q, div_d;
  logic             strobe;
  logic             tick_q;

  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            rise_q, rise_d;
  logic [N_BTN-1:0]            fall_q, fall_d;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign x = ACTIVE_LOW ? ~btn_in : btn_in;

  // With TICK_DIV=1 the counter sits at 0 == DIV_LAST, so strobe is constant.
  assign strobe = (div_q == DIV_LAST);

  always_comb begin
    div_d = strobe ? '0 : div_q + 1'b1;
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    if (strobe) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (s2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= x;
      s2_q    <= s1_q;
      div_q   <= div_d;
      tick_q  <= strobe;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Directed bench for multi_btn_debouncer: TICK_DIV=4, N_STABLE=3, two
// channels, plus an active-low instance sharing clock and reset.
module tb_multi_btn_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_in;
  logic [1:0] btn_level, btn_rise, btn_fall;
  logic       sample_tick;
  logic [1:0] al_in;
  logic [1:0] al_level, al_rise, al_fall;
  logic       al_tick;

  int total;
  int bad;

  multi_btn_debouncer #(
    .N_BTN(2), .CLOCK_FREQ(1), .T_SAMPLE_US(4),
    .N_STABLE(3), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise),
    .btn_fall(btn_fall), .sample_tick(sample_tick)
  );

  multi_btn_debouncer #(
    .N_BTN(2), .CLOCK_FREQ(1), .T_SAMPLE_US(4),
    .N_STABLE(3), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_in(al_in),
    .btn_level(al_level), .btn_rise(al_rise),
    .btn_fall(al_fall), .sample_tick(al_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         hold;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } seg_t;

  localparam int NSEG = 21;
  seg_t tbl [NSEG];

  task automatic chk(input string nm, input int idx,
                     input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] lvl/rise/fall/tick got=%b want=%b",
               nm, idx, got, want);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] el, er, ef;
    total = 0;
    bad   = 0;

    // clean press/release on ch0 (phase k counted from reset release)
    tbl[0]  = '{11, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1,  1'b1, 2'b01, 2'b01, 2'b01, 2'b00};
    tbl[2]  = '{1,  1'b1, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[3]  = '{7,  1'b1, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[4]  = '{11, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00};
    tbl[5]  = '{1,  1'b1, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[6]  = '{1,  1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{6,  1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    // bounce 6 high / 2 low / 6 high, low gap lands on a sample
    tbl[8]  = '{6,  1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{2,  1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{6,  1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    // simultaneous press and release of both channels
    tbl[12] = '{12, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[13] = '{1,  1'b1, 2'b11, 2'b11, 2'b11, 2'b00};
    tbl[14] = '{1,  1'b1, 2'b11, 2'b11, 2'b00, 2'b00};
    tbl[15] = '{10, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00};
    tbl[16] = '{1,  1'b1, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[17] = '{1,  1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    // reset after two ticks of a ch1 press, then a full 3-tick accept
    tbl[18] = '{7,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[19] = '{1,  1'b0, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[20] = '{11, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};

    rst_n  = 1'b0;
    btn_in = 2'b00;
    al_in  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      chk("reset", i,
          {btn_level, btn_rise, btn_fall, sample_tick}, 7'b0);
      chk("reset_al", i,
          {al_level, al_rise, al_fall, al_tick}, 7'b0);
    end

    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      clk_step();
      chk("idle", k, {btn_level, btn_rise, btn_fall, sample_tick},
          {6'b0, (k % 4) == 0});
      chk("idle_al", k, {al_level, al_rise, al_fall, al_tick},
          {6'b0, (k % 4) == 0});
    end

    prev = 2'b00;
    for (int s = 0; s < NSEG; s++) begin
      btn_in = tbl[s].btn;
      rst_n  = tbl[s].rst;
      for (int c = 0; c < tbl[s].hold; c++) begin
        clk_step();
        if (c == tbl[s].hold - 1) begin
          el = tbl[s].lvl;
          er = tbl[s].rise;
          ef = tbl[s].fall;
        end else begin
          el = tbl[s].rst ? prev : 2'b00;
          er = 2'b00;
          ef = 2'b00;
        end
        chk("seg", s * 100 + c,
            {1'b0, btn_level, btn_rise, btn_fall},
            {1'b0, el, er, ef});
      end
      prev = tbl[s].lvl;
    end

    // ch1 accepted exactly 12 clocks after reset release
    clk_step();
    chk("rst_rise", 12, {1'b0, btn_level, btn_rise, btn_fall},
        {1'b0, 2'b10, 2'b10, 2'b00});
    clk_step();
    chk("rst_hold", 13, {1'b0, btn_level, btn_rise, btn_fall},
        {1'b0, 2'b10, 2'b00, 2'b00});

    // active-low pin 0 driven low at phase 13
    al_in = 2'b10;
    for (int j = 14; j <= 27; j++) begin
      clk_step();
      chk("al_press", j, {al_level, al_rise, al_fall, al_tick},
          {1'b0, j >= 24, 1'b0, j == 24, 2'b00, (j % 4) == 0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
